// File: rtl/microsequencer_pkg.sv
// Shared definitions for the microsequencer: widths, MIR field map and
// the packed microinstruction layout.
package microsequencer_pkg;

    localparam int ADDR     = 9;
    localparam int CS_DEPTH = 512;
    localparam int MIR_W    = 36;
    localparam int UI_W     = 24;

    localparam int NA_LSB   = 27;
    localparam int NA_W     = 9;
    localparam int JMPC_BIT = 26;
    localparam int JAMN_BIT = 25;
    localparam int JAMZ_BIT = 24;
    localparam int SH_LSB   = 22;
    localparam int SH_W     = 2;
    localparam int ALU_LSB  = 16;
    localparam int ALU_W    = 6;
    localparam int C_LSB    = 7;
    localparam int C_W      = 9;
    localparam int MEM_LSB  = 4;
    localparam int MEM_W    = 3;
    localparam int B_LSB    = 0;
    localparam int B_W      = 4;

    typedef struct packed {
        logic [NA_W-1:0]  next_addr;
        logic             jmpc;
        logic             jamn;
        logic             jamz;
        logic [SH_W-1:0]  shift;
        logic [ALU_W-1:0] alu;
        logic [C_W-1:0]   c;
        logic [MEM_W-1:0] mem;
        logic [B_W-1:0]   b;
    } mir_t;

endpackage

// File: rtl/microsequencer_if.sv
// Control/store-load bundle between the microsequencer and its driver.
interface microsequencer_if #(
    parameter int ADDR  = microsequencer_pkg::ADDR,
    parameter int MIR_W = microsequencer_pkg::MIR_W,
    parameter int UI_W  = microsequencer_pkg::UI_W
) ();

    logic             run;
    logic             n;
    logic             z;
    logic [7:0]       mbr;
    logic             cs_we;
    logic [ADDR-1:0]  cs_addr;
    logic [MIR_W-1:0] cs_wdata;
    logic [UI_W-1:0]  microinst;
    logic [ADDR-1:0]  mpc;

    modport master (
        output run, n, z, mbr, cs_we, cs_addr, cs_wdata,
        input  microinst, mpc
    );

    modport slave (
        input  run, n, z, mbr, cs_we, cs_addr, cs_wdata,
        output microinst, mpc
    );

endinterface

// File: rtl/microsequencer_control_store.sv
// Control store: synchronous write, registered read; the read register is the MIR.
module control_store #(
    parameter int ADDR     = microsequencer_pkg::ADDR,
    parameter int CS_DEPTH = microsequencer_pkg::CS_DEPTH,
    parameter int MIR_W    = microsequencer_pkg::MIR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic [ADDR-1:0]  raddr,
    output logic [MIR_W-1:0] rdata,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [MIR_W-1:0] wdata
);

    logic [MIR_W-1:0] mem [CS_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: next-address logic, mpc register and microinstruction gating
// around a synchronous control store.
module microsequencer #(
    parameter int ADDR     = microsequencer_pkg::ADDR,
    parameter int CS_DEPTH = microsequencer_pkg::CS_DEPTH,
    parameter int MIR_W    = microsequencer_pkg::MIR_W
) (
    input logic               clk,
    input logic               reset,
    microsequencer_if.slave   bus
);

    import microsequencer_pkg::*;

    logic [MIR_W-1:0] mir_q;
    mir_t             mir;
    logic [ADDR-1:0]  next_addr;
    logic [ADDR-1:0]  mpc_q;
    logic             fetch;
    logic             load;

    assign mir   = mir_q;
    assign fetch = bus.run & ~reset;
    assign load  = bus.cs_we & ~bus.run & ~reset;

    // Flags come straight from the datapath for the MIR being presented now.
    always_comb begin
        next_addr         = '0;
        next_addr[ADDR-1] = mir.next_addr[ADDR-1]
                          | (mir.jamn & bus.n)
                          | (mir.jamz & bus.z);
        next_addr[ADDR-2:0] = mir.jmpc
                            ? (mir.next_addr[ADDR-2:0] | bus.mbr)
                            : mir.next_addr[ADDR-2:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mpc_q <= '0;
        end else if (bus.run) begin
            mpc_q <= next_addr;
        end
    end

    control_store #(
        .ADDR     (ADDR),
        .CS_DEPTH (CS_DEPTH),
        .MIR_W    (MIR_W)
    ) u_cs (
        .clk   (clk),
        .reset (reset),
        .re    (fetch),
        .raddr (next_addr),
        .rdata (mir_q),
        .we    (load),
        .waddr (bus.cs_addr),
        .wdata (bus.cs_wdata)
    );

    assign bus.mpc       = mpc_q;
    assign bus.microinst = bus.run
                         ? {mir.shift, mir.alu, mir.c, mir.mem, mir.b}
                         : '0;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench: directed scenarios plus randomized run against a
// fetch-level reference model.
module tb_microsequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    microsequencer_if bus ();

    microsequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [35:0] cs_m [512];
    logic [8:0]  mpc_m;
    logic [35:0] mir_m;

    function automatic logic [8:0] next_of(logic [35:0] w, logic nf,
                                           logic zf, logic [7:0] ob);
        int a;
        a = int'(w[35:27]);
        if (w[26]) a = a | int'(ob);
        if ((w[25] && nf) || (w[24] && zf)) a = a | 256;
        return a[8:0];
    endfunction

    function automatic logic [35:0] mk(logic [8:0] na, logic jc, logic jn,
                                       logic jz, logic [7:0] alu,
                                       logic [15:0] rest);
        return {na, jc, jn, jz, alu, rest};
    endfunction

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic check(string nm, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: one fetch per running edge, loads only while stopped.
    always @(posedge clk) begin
        if (reset) begin
            mpc_m = 9'h000;
            mir_m = 36'h0;
        end else if (bus.run) begin
            mpc_m = next_of(mir_m, bus.n, bus.z, bus.mbr);
            mir_m = cs_m[mpc_m];
        end else if (bus.cs_we) begin
            cs_m[bus.cs_addr] = bus.cs_wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mpc", 36'(bus.mpc), 36'(mpc_m));
            check("microinst", 36'(bus.microinst),
                  bus.run ? 36'(mir_m[23:0]) : 36'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [35:0] d);
        bus.run      = 1'b0;
        bus.cs_we    = 1'b1;
        bus.cs_addr  = a;
        bus.cs_wdata = d;
        tick();
        bus.cs_we    = 1'b0;
    endtask

    task automatic go();
        reset   = 1'b1;
        bus.run = 1'b0;
        tick();
        reset   = 1'b0;
        bus.run = 1'b1;
        #1;
    endtask

    logic [35:0] d, e, w, w0;

    initial begin
        reset        = 1'b1;
        bus.run      = 1'b0;
        bus.n        = 1'b0;
        bus.z        = 1'b0;
        bus.mbr      = 8'h00;
        bus.cs_we    = 1'b0;
        bus.cs_addr  = 9'h000;
        bus.cs_wdata = 36'h0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_mpc", 36'(bus.mpc), 36'h0);
        check("reset_ui", 36'(bus.microinst), 36'h0);
        reset = 1'b0;

        for (int i = 0; i < 512; i++) wr(9'(i), rnd36());

        // First-fetch latency
        wr(9'h000, mk(9'h005, 0, 0, 0, 8'h3C, 16'h1234));
        go();
        check("c1_mpc", 36'(bus.mpc), 36'h0);
        check("c1_ui", 36'(bus.microinst), 36'h0);
        tick();
        check("c2_mpc", 36'(bus.mpc), 36'h0);
        check("c2_alu", 36'(bus.microinst[23:16]), 36'h3C);
        tick();
        check("c3_mpc", 36'(bus.mpc), 36'h005);

        wr(9'h000, mk(9'h092, 0, 0, 1, 8'h00, 16'h0));
        go(); bus.z = 1'b1; tick(); tick();
        check("jamz_1", 36'(bus.mpc), 36'h192);
        go(); bus.z = 1'b0; tick(); tick();
        check("jamz_0", 36'(bus.mpc), 36'h092);

        wr(9'h000, mk(9'h010, 0, 1, 0, 8'h00, 16'h0));
        go(); bus.n = 1'b1; bus.z = 1'b1; tick(); tick();
        check("jamn", 36'(bus.mpc), 36'h110);
        bus.n = 1'b0; bus.z = 1'b0;

        wr(9'h000, mk(9'h100, 1, 0, 0, 8'h00, 16'h0));
        go(); bus.mbr = 8'h60; tick(); tick();
        check("jmpc_60", 36'(bus.mpc), 36'h160);
        wr(9'h000, mk(9'h000, 1, 0, 0, 8'h00, 16'h0));
        go(); bus.mbr = 8'hFF; tick(); tick();
        check("jmpc_ff", 36'(bus.mpc), 36'h0FF);
        bus.mbr = 8'h00;

        wr(9'h000, mk(9'h1FF, 0, 0, 0, 8'h00, 16'h0));
        wr(9'h1FF, mk(9'h000, 0, 0, 0, 8'h42, 16'h0));
        go(); tick(); tick();
        check("top_addr", 36'(bus.mpc), 36'h1FF);
        tick();
        check("wrap", 36'(bus.mpc), 36'h000);

        // Store writes: stopped vs running, and write under the current mpc
        d = mk(9'h000, 0, 0, 0, 8'hA5, 16'h5A5A);
        e = mk(9'h000, 0, 0, 0, 8'hC3, 16'h0F0F);
        wr(9'h020, d);
        wr(9'h000, mk(9'h020, 0, 0, 0, 8'h00, 16'h0));
        go(); tick(); tick();
        check("wr_mpc", 36'(bus.mpc), 36'h020);
        check("wr_ui", 36'(bus.microinst), 36'(d[23:0]));
        wr(9'h020, e);
        bus.run = 1'b1; #1;
        check("wr_hold", 36'(bus.microinst), 36'(d[23:0]));
        bus.cs_we = 1'b1; bus.cs_addr = 9'h020; bus.cs_wdata = 36'hF_FFFF_FFFF;
        tick(); tick();
        check("wr_new", 36'(bus.microinst), 36'(e[23:0]));
        tick(); tick();
        check("wr_ignored", 36'(bus.microinst), 36'(e[23:0]));
        bus.cs_we = 1'b0;

        // Reset mid-run
        w0 = mk(9'h1A3, 0, 0, 0, 8'h11, 16'h2222);
        w  = mk(9'h000, 0, 0, 0, 8'h77, 16'hBEEF);
        wr(9'h000, w0);
        wr(9'h1A3, w);
        go(); tick(); tick();
        check("mid_mpc", 36'(bus.mpc), 36'h1A3);
        reset = 1'b1; tick();
        check("rst_mpc", 36'(bus.mpc), 36'h000);
        check("rst_ui", 36'(bus.microinst), 36'h0);
        bus.run = 1'b0; bus.cs_we = 1'b1;
        bus.cs_addr = 9'h1A3; bus.cs_wdata = 36'h0;
        tick();
        bus.cs_we = 1'b0; reset = 1'b0; bus.run = 1'b1;
        tick();
        check("post_mpc", 36'(bus.mpc), 36'h000);
        check("post_ui", 36'(bus.microinst), 36'(w0[23:0]));
        tick();
        check("intact", 36'(bus.microinst), 36'(w[23:0]));

        for (int i = 0; i < 3000; i++) begin
            bus.n        = 1'($urandom_range(1));
            bus.z        = 1'($urandom_range(1));
            bus.mbr      = 8'($urandom_range(255));
            bus.run      = ($urandom_range(7) != 0);
            bus.cs_we    = ($urandom_range(3) == 0);
            bus.cs_addr  = 9'($urandom_range(511));
            bus.cs_wdata = rnd36();
            reset        = ($urandom_range(63) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- ADDR, 9, control-store address width
- CS_DEPTH, 512, control-store words
- MIR_W, 36, microinstruction width: NEXT_ADDRESS 9 + JAM 3 + ALU 8 + C 9 + MEM 3 + B 4
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge
- reset, input, 1, synchronous, active-high
- run, input, 1, 1 = sequence microcode, 0 = hold state
- n, input, 1, ALU negative flag from datapath for the current microinstruction
- z, input, 1, ALU zero flag from datapath for the current microinstruction
- mbr, input, 8, opcode byte used for JMPC multiway branch
- cs_we, input, 1, control-store write strobe
- cs_addr, input, ADDR, control-store write address
- cs_wdata, input, MIR_W, control-store write data
- microinst, output, ALU+C+MEM+B (24), datapath control word
- mpc, output, ADDR, current micro-program counter

Function
REQ-003 MIR field map SHALL be: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:22] shifter, [21:16] ALU, [15:7] C, [6:4] MEM, [3:0] B.
REQ-004 While run=1, microinst SHALL equal MIR[23:0]; while run=0 it SHALL be all-zero (NOP).
REQ-005 The next address SHALL be computed combinationally:
- bit 8 = NEXT_ADDRESS[8] | (JAMN & n) | (JAMZ & z)
- bits 7:0 = JMPC ? (NEXT_ADDRESS[7:0] | mbr) : NEXT_ADDRESS[7:0]
REQ-006 On each rising edge with run=1 and reset=0, the block SHALL load mpc <= next address and MIR <= CS[next address], giving one microinstruction per cycle.
REQ-007 A NOP MIR (all-zero) SHALL produce next address 0x000.
REQ-008 With run=0, mpc and MIR SHALL hold their values.
REQ-009 A control-store write (CS[cs_addr] <= cs_wdata) SHALL occur on a rising edge only when cs_we=1 and run=0.
REQ-010 cs_we=1 with run=1 SHALL be ignored, with no store change.
REQ-011 A write to the address currently held in mpc SHALL NOT alter MIR; the new word takes effect only on the next fetch of that address.
REQ-012 Address arithmetic SHALL be 9-bit with no carry: OR-ing never overflows, and address 0x1FF branching to 0x000 is legal.
REQ-013 n and z SHALL be sampled in the same cycle that the microinstruction producing them is presented on microinst; there SHALL be no extra flag latency.

Reset
REQ-014 On a rising edge with reset=1, the block SHALL set mpc=0x000 and MIR=0; microinst therefore reads 0 (NOP).
REQ-015 Reset SHALL take priority over run and cs_we.
REQ-016 Reset SHALL NOT clear control-store contents.
REQ-017 If reset is asserted mid-program, the next fetch after release with run=1 SHALL be CS[0x000].

Structure
REQ-018 ADDR, MIR_W, the field offsets/widths of REQ-003, and a packed microinstruction struct typedef SHALL live in the shared definitions package, alongside ALU, C, MEM, B.
REQ-019 Storage SHALL be one sub-module, control_store: a CS_DEPTH x MIR_W array with synchronous write and synchronous read, both on clk.
REQ-020 The sequencer SHALL contain only the mpc register, the next-address logic and the output gating.

Verification
REQ-021 Reset, then run=1 with CS[0]=NEXT 0x005 and ALU field 0x3C -> cycle 1 microinst=0 and mpc=0x000; cycle 2 mpc=0x000 and microinst ALU=0x3C; cycle 3 mpc=0x005.
REQ-022 JAMZ=1, NEXT=0x092, z=1 -> next mpc=0x192; same with z=0 -> 0x092.
REQ-023 JAMN=1, NEXT=0x010, n=1, z=1, JAMZ=0 -> next mpc=0x110.
REQ-024 JMPC=1, NEXT=0x100, mbr=0x60 -> next mpc=0x160; NEXT=0x000, mbr=0xFF -> 0x0FF.
REQ-025 run=0, cs_we=1, cs_addr=0x020, data D -> a later fetch of 0x020 returns D; the same write with run=1 -> CS unchanged and microinst unaffected.
REQ-026 reset pulse mid-run at mpc=0x1A3 -> next edge mpc=0x000 and microinst=0; CS contents intact.
